// File: rtl/common.sv
// +--------------------------------------------------------------------------+
// | common : pipeline-wide scalar types and the hazard-unit fetch command     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package common;

  typedef logic [63:0] u64;
  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    MAINTAIN = 4'd0,
    PLUS4    = 4'd1,
    BEQ      = 4'd2,
    BNE      = 4'd3,
    BLT      = 4'd4,
    BGE      = 4'd5,
    BLTU     = 4'd6,
    BGEU     = 4'd7,
    JAL      = 4'd8,
    JALR_P   = 4'd9
  } instfunc_t;

endpackage

`default_nettype wire

// File: rtl/fetch_pcgen_pkg.sv
// +--------------------------------------------------------------------------+
// | fetch_pcgen_pkg : fetch-sequencer state encoding and shared helpers       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package fetch_pcgen_pkg;
  import common::*;

  localparam u64 c_reset_pc = 64'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

  function automatic logic is_branch(input instfunc_t f);
    return f inside {BEQ, BNE, BLT, BGE, BLTU, BGEU};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_target_calc.sv
// +--------------------------------------------------------------------------+
// | pc_target_calc : decides whether decode redirects fetch, and where to     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module pc_target_calc
  import common::*, fetch_pcgen_pkg::*;
(
  input  instfunc_t instfunc,
  input  logic      br_taken,
  input  u64        br_pc,
  input  u64        br_offset,
  output logic      redirect,
  output u64        target
);

  assign redirect = (instfunc == JAL) || (instfunc == JALR_P) ||
                    (is_branch(instfunc) && br_taken);

  // JALR_P already carries the absolute target; everything else is PC-relative.
  assign target = (instfunc == JALR_P) ? br_offset : (br_pc + br_offset);

endmodule

`default_nettype wire

// File: rtl/fetch_pcgen.sv
// +--------------------------------------------------------------------------+
// | fetch_pcgen : PC generator and ibus fetch sequencer feeding the IF/ID     |
// | latch; discards responses made stale by a redirect. Rev 1.0               |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_pcgen
  import common::*, fetch_pcgen_pkg::*;
#(
  parameter u64 RESET_PC = c_reset_pc,
  parameter int INST_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  instfunc_t         instfunc,
  input  logic              br_taken,
  input  u64                br_pc,
  input  u64                br_offset,
  input  logic              id_ready,
  output logic              ireq_valid,
  output u64                ireq_addr,
  input  logic              iresp_data_ok,
  input  logic [INST_W-1:0] iresp_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output u64                inst_pc,
  output logic              busy
);

  fetch_state_t      r_state, w_state_nxt;
  u64                r_pc, w_pc_nxt;
  u64                r_redir, w_redir_nxt;
  logic [INST_W-1:0] r_inst;
  u64                r_inst_pc;
  logic              w_capture;
  logic              w_redirect;
  u64                w_target;

  pc_target_calc u_target (
    .instfunc  (instfunc),
    .br_taken  (br_taken),
    .br_pc     (br_pc),
    .br_offset (br_offset),
    .redirect  (w_redirect),
    .target    (w_target)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_redir   <= '0;
      r_inst    <= '0;
      r_inst_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_redir <= w_redir_nxt;
      if (w_capture) begin
        r_inst    <= iresp_data;
        r_inst_pc <= r_pc;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_redir_nxt = r_redir;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        // A response landing in the same cycle as a redirect is already stale.
        if (iresp_data_ok && w_redirect) begin
          w_pc_nxt = w_target;
        end else if (iresp_data_ok) begin
          w_capture   = 1'b1;
          w_pc_nxt    = r_pc + 64'd4;
          w_state_nxt = S_HOLD;
        end else if (w_redirect) begin
          w_redir_nxt = w_target;
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (iresp_data_ok) begin
          w_pc_nxt    = w_redirect ? w_target : r_redir;
          w_state_nxt = S_REQ;
        end else if (w_redirect) begin
          w_redir_nxt = w_target;
        end
      end
      S_HOLD: begin
        if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_REQ;
        end else if (id_ready && (instfunc != MAINTAIN)) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The request stays up through S_DROP so the bus is never withdrawn.
  assign ireq_valid = (r_state == S_REQ) || (r_state == S_DROP);
  assign busy       = ireq_valid;
  assign ireq_addr  = r_pc;
  assign inst_valid = (r_state == S_HOLD);
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;

endmodule

`default_nettype wire
